// File: rtl/if_fetch_stage.sv
// if_fetch_stage: MIPS instruction fetch with PC, IF/ID register, stall/redirect/halt handling
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'h0000_000C
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] instr_pc,
  input  logic [31:0] instr_in,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        halted,
  output logic [31:0] fetch_count
);
  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;
  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, pc4_q, pc4_d, cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4;
  assign pc_plus4       = pc_q + 32'd4;
  assign instr_pc       = pc_q;
  assign if_id_valid    = valid_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus4 = pc4_q;
  assign halted         = state_q == HALT;
  assign fetch_count    = cnt_q;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    cnt_d   = cnt_q;
    // a bubble is the default whenever the register is not held or filled
    if (state_q == BOOT || redirect_valid || (state_q == HALT && !stall)) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      pc4_d   = 32'd0;
    end
    if (state_q == BOOT) begin
      state_d = RUN;
    end else if (redirect_valid) begin
      pc_d    = {redirect_target[31:2], 2'b00};
      state_d = RUN;
    end else if (state_q == RUN && !stall) begin
      valid_d = 1'b1;
      instr_d = instr_in;
      pc4_d   = pc_plus4;
      cnt_d   = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
      pc_d    = (instr_in == HALT_INSTR) ? pc_q : pc_plus4;
      state_d = (instr_in == HALT_INSTR) ? HALT : RUN;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'd0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed checks of fetch, stall, redirect, halt, wrap and async reset
module tb_if_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n, stall, redirect_valid;
  logic [31:0] redirect_target, instr_pc, instr_in, if_id_instr, if_id_pc_plus4, fetch_count;
  logic        if_id_valid, halted;
  int          n_tests = 0;
  int          n_fail = 0;
  if_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .instr_pc(instr_pc), .instr_in(instr_in),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4),
    .halted(halted), .fetch_count(fetch_count)
  );
  always #5 clk = ~clk;
  // instruction memory: a few fixed words, otherwise a tag derived from the address
  always_comb begin
    instr_in = 32'hA000_0000 ^ instr_pc;
    if (instr_pc == 32'h0)  instr_in = 32'h2008_0001;
    if (instr_pc == 32'h4)  instr_in = 32'h2009_0002;
    if (instr_pc == 32'h20) instr_in = 32'h0000_000C;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [31:0] pc, input logic v,
                         input logic [31:0] ins, input logic [31:0] p4, input logic h,
                         input logic [31:0] cnt);
    chk({tag, ".pc"}, instr_pc, pc);
    chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, v});
    chk({tag, ".instr"}, if_id_instr, ins);
    chk({tag, ".pc4"}, if_id_pc_plus4, p4);
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, h});
    chk({tag, ".count"}, fetch_count, cnt);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    #7;
    chk_all("reset", 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'd0);
    rst_n = 1'b1;
    step(); chk_all("boot", 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'd0);
    step(); chk_all("fetch0", 32'h4, 1'b1, 32'h2008_0001, 32'h4, 1'b0, 32'd1);
    step(); chk_all("fetch4", 32'h8, 1'b1, 32'h2009_0002, 32'h8, 1'b0, 32'd2);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk_all("stall", 32'h8, 1'b1, 32'h2009_0002, 32'h8, 1'b0, 32'd2);
    end
    stall = 1'b0;
    step(); chk_all("fetch8", 32'hC, 1'b1, 32'hA000_0008, 32'hC, 1'b0, 32'd3);
    step(); chk_all("fetchC", 32'h10, 1'b1, 32'hA000_000C, 32'h10, 1'b0, 32'd4);
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h43;
    step(); chk_all("redir_stall", 32'h40, 1'b0, 32'h0, 32'h0, 1'b0, 32'd4);
    stall = 1'b0; redirect_target = 32'h20;
    step(); chk_all("redir20", 32'h20, 1'b0, 32'h0, 32'h0, 1'b0, 32'd4);
    redirect_valid = 1'b0;
    step(); chk_all("halt_fetch", 32'h20, 1'b1, 32'h0000_000C, 32'h24, 1'b1, 32'd5);
    stall = 1'b1;
    step(); chk_all("halt_stall1", 32'h20, 1'b1, 32'h0000_000C, 32'h24, 1'b1, 32'd5);
    step(); chk_all("halt_stall2", 32'h20, 1'b1, 32'h0000_000C, 32'h24, 1'b1, 32'd5);
    stall = 1'b0;
    step(); chk_all("halt_bubble", 32'h20, 1'b0, 32'h0, 32'h0, 1'b1, 32'd5);
    step(); chk_all("halt_bubble2", 32'h20, 1'b0, 32'h0, 32'h0, 1'b1, 32'd5);
    redirect_valid = 1'b1; redirect_target = 32'h100;
    step(); chk_all("halt_redir", 32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 32'd5);
    redirect_valid = 1'b0;
    step(); chk_all("fetch100", 32'h104, 1'b1, 32'hA000_0100, 32'h104, 1'b0, 32'd6);
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFE;
    step(); chk_all("redir_top", 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0, 1'b0, 32'd6);
    redirect_valid = 1'b0;
    step(); chk_all("wrap", 32'h0, 1'b1, 32'h5FFF_FFFC, 32'h0, 1'b0, 32'd7);
    stall = 1'b1;
    step(); chk_all("pre_rst_stall", 32'h0, 1'b1, 32'h5FFF_FFFC, 32'h0, 1'b0, 32'd7);
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'd0);
    #2 rst_n = 1'b1;
    step(); chk_all("reboot", 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'd0);
    stall = 1'b0;
    step(); chk_all("refetch", 32'h4, 1'b1, 32'h2008_0001, 32'h4, 1'b0, 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
